ring_monitor: RTL and testbench
===============================

RING_MONITOR -- requirements
Module: ring_monitor

Interface
REQ-001 Parameter LOCK_N, default 2: number of consecutive correct single-step advances required to enter LOCKED (range 1..15).
REQ-002 Parameter REV_W, default 8: width of the revolution counter REV.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 Q  input  [0:15]  ring state from the upstream 16-stage rotating one-hot register; Q[k]=1 means position k.
REQ-006 EN  input  1  sample enable; Q is evaluated only on clock edges where EN=1.
REQ-007 C  output  [0:3]  registered binary index of the set bit of Q; C[0] is the MSB.
REQ-008 VALID  output  1  registered; 1 for exactly the cycle after an enabled sample in which Q was one-hot.
REQ-009 LOCKED  output  1  registered; 1 while the FSM is in state LOCKED.
REQ-010 ERR  output  1  sticky fault flag; cleared only by RST.
REQ-011 REV  output  [REV_W-1:0]  count of completed revolutions (15->0 wraps) seen while LOCKED.
REQ-012 ERRCNT  output  [3:0]  count of faulty enabled samples; saturates at 15.

Function
REQ-013 One-hot check: a sample is good-shape iff exactly one bit of Q is 1; idx is that bit's position (0..15).
REQ-014 Step check: a sample is in-step iff it is good-shape, prev is valid, and idx == (prev+1) mod 16.
REQ-015 On a good-shape enabled sample, C<=idx, VALID<=1, prev<=idx, and prev becomes valid; otherwise C holds and VALID<=0.
REQ-016 Latency: C and VALID reflect the sample taken one CLK edge earlier.
REQ-017 EN=0: FSM state, prev, good_cnt, C, REV, ERRCNT, and ERR all hold; VALID<=0.
REQ-018 FSM states: HUNT, LOCKED, FAULT; HUNT after reset.
REQ-019 HUNT, in-step sample: good_cnt increments; if the incremented value equals LOCK_N, go to LOCKED and clear good_cnt.
REQ-020 HUNT, good-shape but not in-step (including first sample, prev invalid): good_cnt<=0; stay in HUNT.
REQ-021 HUNT, not good-shape (zero bits or several bits set): good_cnt<=0, ERRCNT increments (saturating), prev becomes invalid; stay in HUNT; ERR is not set.
REQ-022 LOCKED, in-step sample: stay in LOCKED; if prev==15 and idx==0, REV increments modulo 2^REV_W.
REQ-023 LOCKED, any sample that is not in-step (bad shape, skip, repeat, or reverse): go to FAULT, ERR<=1, ERRCNT increments (saturating), prev<=idx if good-shape else prev becomes invalid.
REQ-024 FAULT: lasts exactly one CLK cycle regardless of EN or Q, then HUNT with good_cnt=0; the sample on that edge is otherwise ignored (no C/VALID update, VALID<=0).
REQ-025 LOCKED is 0 in HUNT and FAULT; REV holds outside LOCKED.
REQ-026 ERRCNT at 15 plus a new fault stays 15; ERR already 1 stays 1.
REQ-027 A repeated identical position while LOCKED (upstream clock stalled with EN=1) is a fault; the upstream stage gates EN when it is not advancing.

Reset
REQ-028 RST=1 immediately (without a clock edge) forces: state HUNT, good_cnt=0, prev invalid, C=0, VALID=0, LOCKED=0, ERR=0, REV=0, ERRCNT=0.
REQ-029 RST asserted mid-operation (any state) has the same effect; the first enabled edge after RST deasserts is treated as a first sample (prev invalid).

Verification
REQ-030 Reset, then EN=1 with Q stepping 0,1,2,... one position per edge: VALID=1 from edge 1, C=0,1,2 after edges 1,2,3; LOCKED=1 after edge 3 (LOCK_N=2); ERR=0.
REQ-031 Continue stepping through position 15 and back to 0 (sampled on edge 17): REV=1 after edge 17; after 3 full revolutions, REV=3; ERRCNT=0.
REQ-032 While LOCKED at position 5, drive Q=position 7: after that edge, FAULT, ERR=1, ERRCNT=1, LOCKED=0; next edge HUNT; with correct stepping, relock after LOCK_N further in-step samples; ERR stays 1.
REQ-033 In HUNT, drive Q=16'h0000 and then Q with bits 3 and 9 set: VALID=0 both cycles, ERRCNT=2, ERR=0, C unchanged.
REQ-034 While LOCKED, drop EN for 4 cycles with Q frozen, then resume stepping: all outputs hold (VALID=0), no fault, LOCKED stays 1; 20 bad-shape samples give ERRCNT=15 (saturated).
REQ-035 Assert RST asynchronously between edges while LOCKED with REV=2 and ERR=1: all outputs read 0 before the next edge.

Source files
------------

// File: rtl/ring_monitor.sv
// ring_monitor: checks a 16-stage rotating one-hot ring. It reports the
// encoded position, tracks lock to a correct single-step rotation, counts
// revolutions while locked and keeps a sticky fault flag plus a saturating
// fault count.
module ring_monitor #(
    parameter int LOCK_N = 2,
    parameter int REV_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [0:15]      Q,
    input  logic             EN,
    output logic [0:3]       C,
    output logic             VALID,
    output logic             LOCKED,
    output logic             ERR,
    output logic [REV_W-1:0] REV,
    output logic [3:0]       ERRCNT
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [3:0]       prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [3:0]       c_q, c_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [3:0]       errcnt_q, errcnt_d;

    logic [4:0]       ones;
    logic [3:0]       idx;
    logic [3:0]       prev_nxt;
    logic [3:0]       good_inc;
    logic [3:0]       errcnt_sat;
    logic             good;
    logic             in_step;

    // Population count and position of the set bit of the sampled ring.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (Q[k]) begin
                ones = ones + 5'd1;
                idx  = 4'(k);
            end
        end
    end

    assign good       = (ones == 5'd1);
    assign prev_nxt   = prev_q + 4'd1;
    assign in_step    = good && prev_vld_q && (idx == prev_nxt);
    assign good_inc   = good_cnt_q + 4'd1;
    assign errcnt_sat = (errcnt_q == 4'hF) ? 4'hF : errcnt_q + 4'd1;

    // Next-state and datapath update for the HUNT/LOCKED/FAULT tracker.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        c_d        = c_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        rev_d      = rev_q;
        errcnt_d   = errcnt_q;

        if (state_q == ST_FAULT) begin
            state_d    = ST_HUNT;
            good_cnt_d = '0;
        end else if (EN) begin
            if (good) begin
                c_d        = idx;
                valid_d    = 1'b1;
                prev_d     = idx;
                prev_vld_d = 1'b1;
            end else begin
                prev_vld_d = 1'b0;
            end

            if (state_q == ST_HUNT) begin
                if (in_step) begin
                    if (good_inc == LOCK_TARGET) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end else begin
                    good_cnt_d = '0;
                    if (!good) begin
                        errcnt_d = errcnt_sat;
                    end
                end
            end else begin
                if (in_step) begin
                    if (prev_q == 4'd15 && idx == 4'd0) begin
                        rev_d = rev_q + 1'b1;
                    end
                end else begin
                    state_d  = ST_FAULT;
                    err_d    = 1'b1;
                    errcnt_d = errcnt_sat;
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_HUNT;
            good_cnt_q <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            c_q        <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            rev_q      <= '0;
            errcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            c_q        <= c_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            rev_q      <= rev_d;
            errcnt_q   <= errcnt_d;
        end
    end

    assign C      = c_q;
    assign VALID  = valid_q;
    assign LOCKED = (state_q == ST_LOCKED);
    assign ERR    = err_q;
    assign REV    = rev_q;
    assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: directed stimulus for ring_monitor with a behavioural
// model feeding a scoreboard queue, plus fixed expected values at the
// scenario checkpoints.
module tb_ring_monitor;

    localparam int LOCK_N = 2;
    localparam int REV_W  = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN;
    logic [0:15]      Q;
    logic [0:3]       C;
    logic             VALID;
    logic             LOCKED;
    logic             ERR;
    logic [REV_W-1:0] REV;
    logic [3:0]       ERRCNT;

    typedef struct {
        logic [3:0]       c;
        logic             valid;
        logic             locked;
        logic             err;
        logic [REV_W-1:0] rev;
        logic [3:0]       errcnt;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state: 0 = HUNT, 1 = LOCKED, 2 = FAULT.
    int               m_state;
    int               m_cnt;
    int               m_prev;
    logic             m_pv;
    int               m_c;
    logic             m_valid;
    logic             m_err;
    logic [REV_W-1:0] m_rev;
    int               m_errcnt;

    ring_monitor #(.LOCK_N(LOCK_N), .REV_W(REV_W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Q      (Q),
        .EN     (EN),
        .C      (C),
        .VALID  (VALID),
        .LOCKED (LOCKED),
        .ERR    (ERR),
        .REV    (REV),
        .ERRCNT (ERRCNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [0:15] onehot(input int k);
        logic [0:15] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_assert++;
        assert (act === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, expv);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_cnt    = 0;
        m_prev   = 0;
        m_pv     = 1'b0;
        m_c      = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_rev    = '0;
        m_errcnt = 0;
    endtask

    task automatic model_step(input logic [0:15] q, input logic en);
        int   n;
        int   pos;
        logic good;
        logic ins;
        n   = $countones(q);
        pos = 0;
        for (int k = 15; k >= 0; k--) if (q[k]) pos = k;
        good    = (n == 1);
        ins     = good && m_pv && (pos == (m_prev + 1) % 16);
        m_valid = 1'b0;
        if (m_state == 2) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (en) begin
            if (m_state == 0) begin
                if (ins) begin
                    m_cnt++;
                    if (m_cnt == LOCK_N) begin
                        m_state = 1;
                        m_cnt   = 0;
                    end
                end else begin
                    m_cnt = 0;
                    if (!good) m_errcnt = (m_errcnt < 15) ? m_errcnt + 1 : 15;
                end
            end else begin
                if (ins) begin
                    if (m_prev == 15 && pos == 0) m_rev = m_rev + 1'b1;
                end else begin
                    m_state  = 2;
                    m_err    = 1'b1;
                    m_errcnt = (m_errcnt < 15) ? m_errcnt + 1 : 15;
                end
            end
            if (good) begin
                m_c     = pos;
                m_valid = 1'b1;
                m_prev  = pos;
                m_pv    = 1'b1;
            end else begin
                m_pv = 1'b0;
            end
        end
    endtask

    // One clock edge: predict, push, drive, wait, pop and compare.
    task automatic drive(input logic [0:15] q, input logic en);
        exp_t e;
        model_step(q, en);
        e.c      = 4'(m_c);
        e.valid  = m_valid;
        e.locked = (m_state == 1);
        e.err    = m_err;
        e.rev    = m_rev;
        e.errcnt = 4'(m_errcnt);
        sb.push_back(e);
        Q  = q;
        EN = en;
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("sb_C",      32'(C),      32'(e.c));
        chk("sb_VALID",  32'(VALID),  32'(e.valid));
        chk("sb_LOCKED", 32'(LOCKED), 32'(e.locked));
        chk("sb_ERR",    32'(ERR),    32'(e.err));
        chk("sb_REV",    32'(REV),    32'(e.rev));
        chk("sb_ERRCNT", 32'(ERRCNT), 32'(e.errcnt));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_C",      32'(C),      32'd0);
        chk("rst_VALID",  32'(VALID),  32'd0);
        chk("rst_LOCKED", 32'(LOCKED), 32'd0);
        chk("rst_ERR",    32'(ERR),    32'd0);
        chk("rst_REV",    32'(REV),    32'd0);
        chk("rst_ERRCNT", 32'(ERRCNT), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic [0:15] q2;
        EN = 1'b0;
        Q  = '0;

        // Phase A: lock, revolutions, skip fault, relock, EN hold, repeat fault.
        do_reset();
        for (int e = 1; e <= 49; e++) begin
            drive(onehot((e - 1) % 16), 1'b1);
            if (e <= 3) begin
                chk("first_C", 32'(C), 32'(e - 1));
                chk("first_VALID", 32'(VALID), 32'd1);
            end
            if (e == 2) chk("not_locked_e2", 32'(LOCKED), 32'd0);
            if (e == 3) chk("locked_e3", 32'(LOCKED), 32'd1);
            if (e == 17) chk("rev_e17", 32'(REV), 32'd1);
        end
        chk("rev_3", 32'(REV), 32'd3);
        chk("errcnt_0", 32'(ERRCNT), 32'd0);
        chk("err_0", 32'(ERR), 32'd0);
        for (int p = 1; p <= 5; p++) drive(onehot(p), 1'b1);
        drive(onehot(7), 1'b1);
        chk("skip_ERR", 32'(ERR), 32'd1);
        chk("skip_ERRCNT", 32'(ERRCNT), 32'd1);
        chk("skip_LOCKED", 32'(LOCKED), 32'd0);
        drive(onehot(8), 1'b1);
        chk("fault_VALID", 32'(VALID), 32'd0);
        chk("fault_C", 32'(C), 32'd7);
        drive(onehot(8), 1'b1);
        chk("relock_pending", 32'(LOCKED), 32'd0);
        drive(onehot(9), 1'b1);
        chk("relock", 32'(LOCKED), 32'd1);
        chk("relock_ERR", 32'(ERR), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(onehot(9), 1'b0);
            chk("hold_VALID", 32'(VALID), 32'd0);
            chk("hold_LOCKED", 32'(LOCKED), 32'd1);
            chk("hold_C", 32'(C), 32'd9);
        end
        drive(onehot(10), 1'b1);
        drive(onehot(11), 1'b1);
        chk("resume_LOCKED", 32'(LOCKED), 32'd1);
        chk("resume_ERRCNT", 32'(ERRCNT), 32'd1);
        drive(onehot(11), 1'b1);
        chk("repeat_LOCKED", 32'(LOCKED), 32'd0);
        chk("repeat_ERRCNT", 32'(ERRCNT), 32'd2);

        // Phase B: bad shapes in HUNT, saturation of ERRCNT.
        do_reset();
        drive(onehot(4), 1'b1);
        chk("hunt_C4", 32'(C), 32'd4);
        drive(16'h0000, 1'b1);
        chk("zero_VALID", 32'(VALID), 32'd0);
        q2    = '0;
        q2[3] = 1'b1;
        q2[9] = 1'b1;
        drive(q2, 1'b1);
        chk("multi_VALID", 32'(VALID), 32'd0);
        chk("multi_ERRCNT", 32'(ERRCNT), 32'd2);
        chk("multi_ERR", 32'(ERR), 32'd0);
        chk("multi_C", 32'(C), 32'd4);
        for (int i = 0; i < 18; i++) drive((i % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b1);
        chk("errcnt_sat", 32'(ERRCNT), 32'd15);
        drive(onehot(5), 1'b1);
        drive(onehot(6), 1'b1);
        chk("after_bad_not_locked", 32'(LOCKED), 32'd0);

        // Phase C: reach REV=2 with ERR=1 while LOCKED, then async reset.
        do_reset();
        for (int e = 1; e <= 17; e++) drive(onehot((e - 1) % 16), 1'b1);
        drive(onehot(2), 1'b1);
        drive(onehot(3), 1'b1);
        drive(onehot(3), 1'b1);
        drive(onehot(4), 1'b1);
        for (int p = 5; p <= 16; p++) drive(onehot(p % 16), 1'b1);
        chk("c_REV2", 32'(REV), 32'd2);
        chk("c_ERR1", 32'(ERR), 32'd1);
        chk("c_LOCKED", 32'(LOCKED), 32'd1);
        #2;
        do_reset();
        drive(onehot(1), 1'b1);
        chk("post_rst_first", 32'(LOCKED), 32'd0);
        drive(onehot(2), 1'b1);
        drive(onehot(3), 1'b1);
        chk("post_rst_lock", 32'(LOCKED), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
